// File: rtl/psum_drain.sv
// psum_drain: captures completed PE output rows into a row FIFO and
// serializes them one word per beat onto a valid/ready stream.
// Optional build macro: PSUM_DRAIN_RELU_EN (zeroes words whose sign bit is set
// at the output mux only; FIFO contents are never altered).
//
// state | meaning
// IDLE  | no row in the output register, waiting for the FIFO to hold a row
// SEND  | output register holds a row, presenting word m_index on the stream
module psum_drain #(
  parameter int WORDWIDTH = 32,
  parameter int NUM1      = 14,
  parameter int NUM2      = 5,
  parameter int DEPTH     = 4,
  localparam int OUT_NUM  = NUM1 + 1 - NUM2,
  localparam int IW       = $clog2(OUT_NUM),
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORDWIDTH*OUT_NUM-1:0] result_in,
  input  logic                         sum_enable,
  input  logic                         clear,
  output logic [WORDWIDTH-1:0]         m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [IW-1:0]                m_index,
  output logic                         m_last,
  output logic [LW-1:0]                level,
  output logic                         overflow
);

  localparam int ROWW = WORDWIDTH * OUT_NUM;
  localparam int PW   = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [ROWW-1:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q;
  logic [ROWW-1:0]   row_q;
  logic [IW-1:0]     idx_q;
  logic              overflow_q;
  logic              have_row, last_beat, beat, pop, push, drop;
  logic [WORDWIDTH-1:0] word;

  assign have_row  = (level_q != '0);
  assign last_beat = (idx_q == IW'(OUT_NUM - 1));
  assign beat      = (state == SEND) && m_ready;

  // Next-state and pop decision; clear overrides everything and never pops.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (have_row) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (beat && last_beat) begin
          if (have_row) pop = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      pop       = 1'b0;
      state_nxt = IDLE;
    end
  end

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push = sum_enable && !clear && ((level_q != LW'(DEPTH)) || pop);
  assign drop = sum_enable && !clear && (level_q == LW'(DEPTH)) && !pop;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Row storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Output row register and word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (pop) begin
      row_q <= mem[rd_ptr];
      idx_q <= '0;
    end else if (beat && !last_beat) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Sticky drop flag, cleared only by reset or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       overflow_q <= 1'b0;
    else if (clear) overflow_q <= 1'b0;
    else if (drop)  overflow_q <= 1'b1;
  end

  assign word = row_q[WORDWIDTH*idx_q +: WORDWIDTH];

`ifdef PSUM_DRAIN_RELU_EN
  assign m_data = word[WORDWIDTH-1] ? '0 : word;
`else
  assign m_data = word;
`endif

  assign m_valid  = (state == SEND);
  assign m_last   = m_valid && last_beat;
  assign m_index  = idx_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: stimulus pushes expected beats into a queue,
// an independent monitor pops and compares on every handshake.
module tb_psum_drain;

  localparam int WW   = 32;
  localparam int ON   = 10;
  localparam int ROWW = WW * ON;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic            clk = 0;
  logic            rst;
  logic [ROWW-1:0] result_in;
  logic            sum_enable;
  logic            clear;
  logic [WW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready = 0;
  logic [3:0]      m_index;
  logic            m_last;
  logic [2:0]      level;
  logic            overflow;

  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 1;
  int    pat_cnt = 0;
  beat_t exp_q[$];

  logic        hold_v = 0;
  logic [31:0] hold_d;
  logic [3:0]  hold_i;

  psum_drain dut (
    .clk(clk), .rst(rst), .result_in(result_in), .sum_enable(sum_enable),
    .clear(clear), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_index(m_index), .m_last(m_last), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef PSUM_DRAIN_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [ROWW-1:0] mk_row(input logic [31:0] base);
    logic [ROWW-1:0] r;
    for (int k = 0; k < ON; k++) r[k*WW +: WW] = base + 32'(k);
    return r;
  endfunction

  task automatic push_exp(input logic [ROWW-1:0] row, input int n_exp);
    beat_t b;
    for (int k = 0; k < n_exp; k++) begin
      b.d    = relu(row[k*WW +: WW]);
      b.idx  = 4'(k);
      b.last = (k == ON - 1);
      exp_q.push_back(b);
    end
  endtask

  // Present a row for one cycle; called just after a rising edge.
  task automatic issue(input logic [ROWW-1:0] row, input int n_exp);
    result_in  = row;
    sum_enable = 1;
    push_exp(row, n_exp);
    @(posedge clk); #1;
    sum_enable = 0;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) begin
        done = 1;
        break;
      end
    end
    check({name, "_drained"}, 64'(done), 64'd1);
    check({name, "_level0"}, 64'(level), 64'd0);
  endtask

  // Ready pattern generator: 0 = low, 1 = high, 2 = 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 0;
      1:       m_ready = 1;
      default: begin
        m_ready = (pat_cnt % 3 == 0);
        pat_cnt++;
      end
    endcase
  end

  // Monitor: hold stability and in-order beat comparison.
  always @(negedge clk) begin
    beat_t e;
    if (hold_v)
      check("hold_stable", {27'd0, m_valid, m_index, m_data}, {27'd0, 1'b1, hold_i, hold_d});
    hold_v = m_valid && !m_ready && !clear && !rst;
    hold_d = m_data;
    hold_i = m_index;
    if (m_valid && m_ready && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%h/%0d required=none", m_data, m_index);
      end else begin
        e = exp_q.pop_front();
        check("beat", {27'd0, m_data, m_index, m_last}, {27'd0, e.d, e.idx, e.last});
      end
    end
  end

  initial begin
    logic            found;
    int              hs, cyc;
    logic [ROWW-1:0] r;
    logic [31:0]     w;

    rst = 1; clear = 0; sum_enable = 0; result_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(m_valid), 0);
    check("rst_level", 64'(level), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_data", 64'(m_data), 0);
    check("rst_index", 64'(m_index), 0);
    check("rst_last", 64'(m_last), 0);
    rst = 0;
    @(posedge clk); #1;

    // Single row, latency of two edges.
    issue(mk_row(32'h1), ON);
    check("lat_valid_early", 64'(m_valid), 0);
    check("lat_level1", 64'(level), 1);
    @(posedge clk); #1;
    check("lat_valid", 64'(m_valid), 1);
    check("lat_level0", 64'(level), 0);
    drain("single");

    // Back-pressure pattern.
    @(negedge clk); rdy_mode = 2;
    @(posedge clk); #1;
    issue(mk_row(32'h100), ON);
    drain("bp");

    // Full FIFO with pop coinciding with a new row.
    @(negedge clk); rdy_mode = 0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) issue(mk_row(32'h200 + 32'(i * 16)), ON);
    check("full_level", 64'(level), 4);
    @(negedge clk); rdy_mode = 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid && m_ready && m_last) begin
        found = 1;
        break;
      end
    end
    check("simpop_found", 64'(found), 1);
    result_in = mk_row(32'h300);
    sum_enable = 1;
    push_exp(result_in, ON);
    @(posedge clk); #1;
    sum_enable = 0;
    check("simpop_level", 64'(level), 4);
    check("simpop_overflow", 64'(overflow), 0);
    drain("simpop");

    // Fill and overflow, then back-to-back drain.
    @(negedge clk); rdy_mode = 0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) issue(mk_row(32'h400 + 32'(i * 16)), ON);
    check("fill_level", 64'(level), 4);
    check("fill_overflow0", 64'(overflow), 0);
    issue(mk_row(32'h500), 0);
    check("drop_overflow", 64'(overflow), 1);
    check("drop_level", 64'(level), 4);
    @(negedge clk); rdy_mode = 1;
    @(negedge clk);
    cyc = 0; hs = 0;
    for (int i = 0; i < 200; i++) begin
      cyc++;
      if (m_valid && m_ready) hs++;
      if (hs == 50) break;
      @(negedge clk);
    end
    check("b2b_cycles", 64'(cyc), 50);
    drain("fill");
    check("overflow_sticky", 64'(overflow), 1);

    // Clear mid-row with two rows queued and a same-cycle row.
    @(negedge clk); rdy_mode = 0;
    @(negedge clk);
    @(posedge clk); #1;
    issue(mk_row(32'h600), 3);
    issue(mk_row(32'h700), 0);
    issue(mk_row(32'h800), 0);
    check("clr_level_pre", 64'(level), 2);
    @(negedge clk); rdy_mode = 1;
    hs = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      if (hs == 3) begin
        found = 1;
        break;
      end
    end
    check("clr_found", 64'(found), 1);
    clear = 1;
    sum_enable = 1;
    result_in = mk_row(32'h900);
    @(posedge clk); #1;
    clear = 0;
    sum_enable = 0;
    check("clr_valid", 64'(m_valid), 0);
    check("clr_level", 64'(level), 0);
    check("clr_overflow", 64'(overflow), 0);
    check("clr_last", 64'(m_last), 0);
    drain("clear");

    issue(mk_row(32'hA00), ON);
    drain("after_clear");

    // Sign-bit words for the output ReLU option.
    r = mk_row(32'h10);
    w = 32'hBF800000; r[0*WW +: WW] = w;
    w = 32'h3F800000; r[1*WW +: WW] = w;
    w = 32'h80000000; r[2*WW +: WW] = w;
    issue(r, ON);
    drain("relu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Downstream stage of the PE. Captures each completed output row that the PE presents on `result` when `sum_enable` pulses.
- Buffers captured rows in a small FIFO, then serializes them one word per beat onto a valid/ready stream for the output write-back path.
- Decouples PE row completion from back-pressure in the memory/write-back side.

Parameters:
- WORDWIDTH, 32, bits per word (IEEE-754 single in the current datapath).
- NUM1, 14, activation row length fed to the PE.
- NUM2, 5, kernel length used by the PE.
- DEPTH, 4, number of full rows the FIFO holds; power of two, ≥2.
- Derived (localparam): OUT_NUM = NUM1+1-NUM2 (10 by default), words per row.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- result_in  in  WORDWIDTH*OUT_NUM  row from PE; word k = bits [(k+1)*WORDWIDTH-1 : k*WORDWIDTH].
- sum_enable  in  1  single-cycle strobe, row on result_in valid this cycle.
- clear  in  1  synchronous flush (start of new layer).
- m_data  out  WORDWIDTH  current output word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts word when m_valid&m_ready.
- m_index  out  $clog2(OUT_NUM)  index of m_data within its row.
- m_last  out  1  high with word OUT_NUM-1 of a row.
- level  out  $clog2(DEPTH)+1  rows stored in the FIFO, excluding the row being serialized.
- overflow  out  1  sticky: a row was dropped.

Behaviour:
- Reset (rst=1, async): FIFO empty, wr/rd pointers 0, level=0, FSM=IDLE, m_valid=0, m_data=0, m_index=0, m_last=0, overflow=0.
- Push (accepted row write):
  - Occurs when sum_enable=1 and (level<DEPTH or a pop happens the same cycle).
  - Row written at the edge; level increments unless a pop coincides.
- Drop: sum_enable=1 with level==DEPTH and no same-cycle pop. The row is discarded, overflow set to 1; it stays set until rst or clear.
- FSM states: IDLE, SEND.
  - IDLE: if level>0, pop the head row into the output shift register, m_index←0, go to SEND. Otherwise stay.
  - SEND: m_valid=1, m_data=word[m_index] (ReLU option below), m_last=(m_index==OUT_NUM-1).
    - On m_valid&m_ready with m_index<OUT_NUM-1: m_index+1.
    - On the m_last handshake: if level>0, pop the next row, m_index←0, stay in SEND (back-to-back, no bubble). Else go to IDLE, m_valid←0.
    - m_ready low: m_data, m_index, m_valid held stable; no word is skipped or duplicated.
- Latency: sum_enable at edge t into an empty, idle block gives m_valid=1 from edge t+1+1 (the IDLE pop registers the row). Minimum 2 cycles.
- Throughput: 1 word/cycle with m_ready held high; one row per OUT_NUM cycles.
- Pointers wrap modulo DEPTH.
- Level rules:
  - Push and pop in the same cycle leave level unchanged.
  - A push into an empty FIFO while in IDLE is not popped until the next cycle (no bypass).
- Clear (sync):
  - Empties the FIFO, sets FSM to IDLE, drops m_valid next cycle, clears overflow.
  - Clear has priority over a same-cycle sum_enable, and that row is discarded without setting overflow.
  - A clear mid-row aborts the row; the consumer sees no m_last for it.
- Reset mid-operation: immediate return to reset values, in-flight data lost.

Optional Feature:
- Macro PSUM_DRAIN_RELU_EN.
- When defined: m_data = (word[WORDWIDTH-1]==1) ? 0 : word. Negative floats and -0.0 leave as +0.0; applied combinationally at the output mux, with no added latency.
- When undefined: m_data = word unchanged.
- FIFO contents are never modified in either case.

Test Plan:
- Single row: after reset, one sum_enable with word k = k+1 (0x1..0xA), m_ready=1 → m_valid rises 2 cycles later; 10 beats 0x1..0xA with m_index 0..9; m_last only on 0xA; then m_valid=0 and level=0.
- Back-pressure: same row, m_ready toggled 1,0,0,1,... → each word appears exactly once, in order; m_data is stable while m_ready=0.
- Fill/overflow (DEPTH=4): m_ready=0, six sum_enable rows R0..R5 → row R0 in the shift register, level=4 after R4, R5 dropped, overflow=1. Then m_ready=1 → R0..R4 emitted back-to-back with no bubble between m_last and the next word 0; R5 is never seen.
- Full with simultaneous pop: level=4, m_last handshake in the same cycle as sum_enable → row accepted, overflow stays 0, level stays 4.
- Clear mid-row: clear after 3 words of a row with 2 rows queued → m_valid=0 the next cycle, level=0, overflow=0, no m_last emitted. A subsequent row is output normally.
- ReLU (macro defined): row words 0xBF800000, 0x3F800000, 0x80000000 → outputs 0x00000000, 0x3F800000, 0x00000000. With the macro undefined → outputs unchanged.
